// File: rtl/axi_core_bridge.sv
// axi_core_bridge: Core AXI4 master (IDs) to SoC AXI slave (no IDs) glue + Core reset sequencer.
// Optional feature macro BRIDGE_PERF_EN adds saturating read/write burst counters.

module axi_core_bridge_idq #(
  parameter int W = 4,
  parameter int D = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(D) + 1;

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [W-1:0]  mem [D];

  assign empty = (wptr == rptr);
  assign full  = (wptr[PW-1] != rptr[PW-1]) &&
                 (wptr[PW-2:0] == rptr[PW-2:0]);
  assign dout  = empty ? '0 : mem[rptr[PW-2:0]];

  // pointers; flush empties the queue, storage is left as is
  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // id storage write
  always_ff @(posedge clock) begin
    if (push) mem[wptr[PW-2:0]] <= din;
  end
endmodule

module axi_core_bridge #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ID_W     = 4,
  parameter int MAX_OUT  = 4,
  parameter int RST_HOLD = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                mb_reset,
  input  logic                calib_done,
  output logic                core_reset,
  // core AW
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [ID_W-1:0]     s_awid,
  input  logic [7:0]          s_awlen,
  input  logic [2:0]          s_awsize,
  input  logic [1:0]          s_awburst,
  // core W
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  // core B
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [1:0]          s_bresp,
  output logic [ID_W-1:0]     s_bid,
  // core AR
  input  logic                s_arvalid,
  output logic                s_arready,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [ID_W-1:0]     s_arid,
  input  logic [7:0]          s_arlen,
  input  logic [2:0]          s_arsize,
  input  logic [1:0]          s_arburst,
  // core R
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic [ID_W-1:0]     s_rid,
  // soc AW
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic [3:0]          m_awcache,
  output logic [2:0]          m_awprot,
  output logic [3:0]          m_awqos,
  output logic                m_awlock,
  // soc W
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  // soc B
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp,
  // soc AR
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic [3:0]          m_arcache,
  output logic [2:0]          m_arprot,
  output logic [3:0]          m_arqos,
  output logic                m_arlock,
  // soc R
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  output logic                proto_err
`ifdef BRIDGE_PERF_EN
  ,
  output logic [31:0]         perf_rd_bursts,
  output logic [31:0]         perf_wr_bursts
`endif
);
  localparam int CW = $clog2(RST_HOLD + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RST_HOLD - 1);

  localparam logic [1:0] ST_HOLD  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          ok;
  logic          run;

  logic          r_full;
  logic          r_empty;
  logic          w_full;
  logic          w_empty;
  logic          r_push;
  logic          r_pop;
  logic          w_push;
  logic          w_pop;
  logic          ar_ok;
  logic          aw_ok;

  assign ok  = calib_done & ~mb_reset;
  assign run = (state == ST_RUN);

  // reset sequencer next-state
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (1'b1)
      (state == ST_HOLD): begin
        if (ok) begin
          state_nx = ST_COUNT;
          cnt_nx   = '0;
        end
      end
      (state == ST_COUNT): begin
        if (!ok) begin
          state_nx = ST_HOLD;
        end else if (cnt == CNT_LAST) begin
          state_nx = ST_RUN;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      (state == ST_RUN): begin
        if (!ok) state_nx = ST_HOLD;
      end
      default: begin
        state_nx = ST_HOLD;
        cnt_nx   = '0;
      end
    endcase
  end

  // reset sequencer state, core reset lags the run state by one cycle
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= ST_HOLD;
      cnt        <= '0;
      core_reset <= 1'b1;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      core_reset <= ~run;
    end
  end

  // AR / R
  assign ar_ok     = run & ~r_full;
  assign m_arvalid = s_arvalid & ar_ok;
  assign s_arready = m_arready & ar_ok;
  assign m_araddr  = s_araddr;
  assign m_arlen   = s_arlen;
  assign m_arsize  = s_arsize;
  assign m_arburst = s_arburst;
  assign m_arcache = 4'b0011;
  assign m_arprot  = 3'b000;
  assign m_arqos   = 4'b0000;
  assign m_arlock  = 1'b0;

  assign r_push   = s_arvalid & s_arready;
  assign r_pop    = s_rvalid & s_rready & m_rlast & ~r_empty;
  assign s_rvalid = m_rvalid & run;
  assign m_rready = run ? s_rready : 1'b1;
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast;

  axi_core_bridge_idq #(
    .W (ID_W),
    .D (MAX_OUT)
  ) u_rq (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (~run),
    .push    (r_push),
    .din     (s_arid),
    .pop     (r_pop),
    .dout    (s_rid),
    .full    (r_full),
    .empty   (r_empty)
  );

  // AW / W / B
  assign aw_ok     = run & ~w_full;
  assign m_awvalid = s_awvalid & aw_ok;
  assign s_awready = m_awready & aw_ok;
  assign m_awaddr  = s_awaddr;
  assign m_awlen   = s_awlen;
  assign m_awsize  = s_awsize;
  assign m_awburst = s_awburst;
  assign m_awcache = 4'b0011;
  assign m_awprot  = 3'b000;
  assign m_awqos   = 4'b0000;
  assign m_awlock  = 1'b0;

  assign m_wvalid = s_wvalid;
  assign s_wready = m_wready;
  assign m_wdata  = s_wdata;
  assign m_wstrb  = s_wstrb;
  assign m_wlast  = s_wlast;

  assign w_push   = s_awvalid & s_awready;
  assign w_pop    = s_bvalid & s_bready & ~w_empty;
  assign s_bvalid = m_bvalid & run;
  assign m_bready = run ? s_bready : 1'b1;
  assign s_bresp  = m_bresp;

  axi_core_bridge_idq #(
    .W (ID_W),
    .D (MAX_OUT)
  ) u_wq (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (~run),
    .push    (w_push),
    .din     (s_awid),
    .pop     (w_pop),
    .dout    (s_bid),
    .full    (w_full),
    .empty   (w_empty)
  );

  // sticky flag: a response beat showed up with no id to reflect
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      proto_err <= 1'b0;
    end else if (run & ((m_rvalid & r_empty) | (m_bvalid & w_empty))) begin
      proto_err <= 1'b1;
    end
  end

`ifdef BRIDGE_PERF_EN
  // saturating burst counters, held at zero while the core is in reset
  always_ff @(posedge clock) begin
    if (!reset_n || core_reset) begin
      perf_rd_bursts <= '0;
      perf_wr_bursts <= '0;
    end else begin
      if (s_rvalid & s_rready & m_rlast & ~&perf_rd_bursts)
        perf_rd_bursts <= perf_rd_bursts + 32'd1;
      if (s_bvalid & s_bready & ~&perf_wr_bursts)
        perf_wr_bursts <= perf_wr_bursts + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_axi_core_bridge.sv
// tb_axi_core_bridge: directed test of axi_core_bridge against a queue-based reference model.
// Reset release is modelled by counting consecutive cycles the release condition held.

module tb_axi_core_bridge;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int ID_W     = 4;
  localparam int MAX_OUT  = 4;
  localparam int RST_HOLD = 16;

  logic clock = 1'b0;
  logic reset_n, mb_reset, calib_done, core_reset;
  logic s_awvalid, s_awready;
  logic [ADDR_W-1:0] s_awaddr;
  logic [ID_W-1:0] s_awid;
  logic [7:0] s_awlen;
  logic [2:0] s_awsize;
  logic [1:0] s_awburst;
  logic s_wvalid, s_wready, s_wlast;
  logic [DATA_W-1:0] s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic s_bvalid, s_bready;
  logic [1:0] s_bresp;
  logic [ID_W-1:0] s_bid;
  logic s_arvalid, s_arready;
  logic [ADDR_W-1:0] s_araddr;
  logic [ID_W-1:0] s_arid;
  logic [7:0] s_arlen;
  logic [2:0] s_arsize;
  logic [1:0] s_arburst;
  logic s_rvalid, s_rready, s_rlast;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0] s_rresp;
  logic [ID_W-1:0] s_rid;
  logic m_awvalid, m_awready, m_awlock;
  logic [ADDR_W-1:0] m_awaddr;
  logic [7:0] m_awlen;
  logic [2:0] m_awsize, m_awprot;
  logic [1:0] m_awburst;
  logic [3:0] m_awcache, m_awqos;
  logic m_wvalid, m_wready, m_wlast;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic m_bvalid, m_bready;
  logic [1:0] m_bresp;
  logic m_arvalid, m_arready, m_arlock;
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0] m_arlen;
  logic [2:0] m_arsize, m_arprot;
  logic [1:0] m_arburst;
  logic [3:0] m_arcache, m_arqos;
  logic m_rvalid, m_rready, m_rlast;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0] m_rresp;
  logic proto_err;
`ifdef BRIDGE_PERF_EN
  logic [31:0] perf_rd_bursts, perf_wr_bursts;
`endif

  axi_core_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
    .MAX_OUT(MAX_OUT), .RST_HOLD(RST_HOLD)
  ) dut (
    .clock(clock), .reset_n(reset_n), .mb_reset(mb_reset),
    .calib_done(calib_done), .core_reset(core_reset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_bid(s_bid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awcache(m_awcache), .m_awprot(m_awprot), .m_awqos(m_awqos),
    .m_awlock(m_awlock),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arcache(m_arcache), .m_arprot(m_arprot), .m_arqos(m_arqos),
    .m_arlock(m_arlock),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .proto_err(proto_err)
`ifdef BRIDGE_PERF_EN
    , .perf_rd_bursts(perf_rd_bursts), .perf_wr_bursts(perf_wr_bursts)
`endif
  );

  always #5 clock = ~clock;

  int npass = 0;
  int ntot  = 0;
  bit armed = 0;

  // reference model state
  int streak = 0;
  bit md_run = 0;
  bit md_core = 1;
  bit md_perr = 0;
  logic [ID_W-1:0] rq[$];
  logic [ID_W-1:0] wq[$];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    ntot++;
    if (got !== want)
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    else
      npass++;
  endtask

  task automatic model_update();
    bit ok, rpop, wpop, rpush, wpush;
    if (!reset_n) begin
      streak = 0; md_run = 0; md_core = 1; md_perr = 0;
      rq.delete(); wq.delete();
      return;
    end
    ok = calib_done && !mb_reset;
    md_core = !md_run;
    if (!md_run) begin
      rq.delete(); wq.delete();
    end else begin
      if (m_rvalid && rq.size() == 0) md_perr = 1;
      if (m_bvalid && wq.size() == 0) md_perr = 1;
      rpop  = m_rvalid && s_rready && m_rlast && rq.size() != 0;
      wpop  = m_bvalid && s_bready && wq.size() != 0;
      rpush = s_arvalid && m_arready && rq.size() < MAX_OUT;
      wpush = s_awvalid && m_awready && wq.size() < MAX_OUT;
      if (rpop) void'(rq.pop_front());
      if (wpop) void'(wq.pop_front());
      if (rpush) rq.push_back(s_arid);
      if (wpush) wq.push_back(s_awid);
    end
    streak = ok ? streak + 1 : 0;
    md_run = (streak >= RST_HOLD + 1);
  endtask

  task automatic compare();
    bit ar_ok, aw_ok;
    ar_ok = md_run && rq.size() < MAX_OUT;
    aw_ok = md_run && wq.size() < MAX_OUT;
    chk("core_reset", core_reset, md_core);
    chk("proto_err", proto_err, md_perr);
    chk("m_arvalid", m_arvalid, s_arvalid && ar_ok);
    chk("s_arready", s_arready, m_arready && ar_ok);
    chk("m_awvalid", m_awvalid, s_awvalid && aw_ok);
    chk("s_awready", s_awready, m_awready && aw_ok);
    chk("m_rready", m_rready, md_run ? s_rready : 1'b1);
    chk("m_bready", m_bready, md_run ? s_bready : 1'b1);
    chk("s_rvalid", s_rvalid, m_rvalid && md_run);
    chk("s_bvalid", s_bvalid, m_bvalid && md_run);
    if (m_rvalid && md_run)
      chk("s_rid", s_rid, rq.size() != 0 ? rq[0] : 4'd0);
    if (m_bvalid && md_run)
      chk("s_bid", s_bid, wq.size() != 0 ? wq[0] : 4'd0);
    chk("m_araddr", m_araddr, s_araddr);
    chk("m_awaddr", m_awaddr, s_awaddr);
    chk("m_wvalid", m_wvalid, s_wvalid);
    chk("s_wready", s_wready, m_wready);
    chk("s_rdata", s_rdata, m_rdata);
    chk("s_rlast", s_rlast, m_rlast);
    chk("ties", {m_arcache, m_arprot, m_arqos, m_arlock,
                 m_awcache, m_awprot, m_awqos, m_awlock},
        {4'b0011, 3'b0, 4'b0, 1'b0, 4'b0011, 3'b0, 4'b0, 1'b0});
  endtask

  // per-cycle comparison against the model, mid-cycle
  initial begin
    forever begin
      @(negedge clock);
      if (armed) compare();
    end
  end

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  initial begin
    reset_n = 0; mb_reset = 0; calib_done = 0;
    s_awvalid = 0; s_awaddr = 32'h1000; s_awid = 0; s_awlen = 0;
    s_awsize = 3'd2; s_awburst = 2'd1;
    s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0;
    s_bready = 0;
    s_arvalid = 0; s_araddr = 32'h2000; s_arid = 0; s_arlen = 0;
    s_arsize = 3'd2; s_arburst = 2'd1;
    s_rready = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 32'h55AA_0000;
    m_rresp = 0; m_rlast = 0;

    // reset state
    repeat (3) tick();
    armed = 1;
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_proto_err", proto_err, 1'b0);

    // release: calib first sampled at edge 10, core_reset falls at edge 27
    reset_n = 1;
    repeat (9) tick();
    calib_done = 1;
    repeat (17) tick();
    chk("rel_c26", core_reset, 1'b1);
    tick();
    chk("rel_c27", core_reset, 1'b0);

    // calib glitch at count 8 restarts the hold count
    mb_reset = 1;
    tick();
    mb_reset = 0;
    repeat (9) tick();
    calib_done = 0;
    tick();
    calib_done = 1;
    tick();
    repeat (16) tick();
    chk("glitch_r16", core_reset, 1'b1);
    tick();
    chk("glitch_r17", core_reset, 1'b0);

    // read id reflection: ids 5,2,9 with len 0,3,1
    m_arready = 1; s_rready = 1;
    s_arvalid = 1;
    s_arid = 4'd5; s_arlen = 8'd0; tick();
    s_arid = 4'd2; s_arlen = 8'd3; tick();
    s_arid = 4'd9; s_arlen = 8'd1; tick();
    s_arvalid = 0;
    begin
      logic [ID_W-1:0] ids [7] = '{4'd5, 4'd2, 4'd2, 4'd2, 4'd2, 4'd9, 4'd9};
      bit lasts [7] = '{1, 0, 0, 0, 1, 0, 1};
      for (int i = 0; i < 7; i++) begin
        m_rvalid = 1; m_rlast = lasts[i]; m_rdata = 32'h55AA_0000 + i;
        #1;
        chk("rd_rid_lit", s_rid, ids[i]);
        tick();
      end
    end
    m_rvalid = 0; m_rlast = 0;
    chk("rd_model_empty", rq.size(), 0);

    // W passthrough
    s_wvalid = 1; s_wdata = 32'hCAFE_0001; s_wstrb = 4'hF; s_wlast = 1;
    #1;
    chk("w_data", m_wdata, 32'hCAFE_0001);
    chk("w_strb_last", {m_wstrb, m_wlast}, {4'hF, 1'b1});
    chk("w_ready0", s_wready, 1'b0);
    s_wvalid = 0; s_wlast = 0;

    // write backpressure at MAX_OUT
    m_awready = 1;
    s_awvalid = 1;
    for (int i = 1; i <= 4; i++) begin
      s_awid = 4'(i);
      tick();
    end
    s_awid = 4'd6;
    #1;
    chk("aw5_blocked", s_awready, 1'b0);
    chk("aw5_mvalid", m_awvalid, 1'b0);
    tick();
    m_bvalid = 1; s_bready = 1;
    #1;
    chk("b1_id", s_bid, 4'd1);
    tick();
    m_bvalid = 0;
    #1;
    chk("aw5_ready", s_awready, 1'b1);
    tick();
    s_awvalid = 0;
    begin
      logic [ID_W-1:0] bids [4] = '{4'd2, 4'd3, 4'd4, 4'd6};
      for (int i = 0; i < 4; i++) begin
        m_bvalid = 1;
        #1;
        chk("b_id_lit", s_bid, bids[i]);
        tick();
      end
    end
    m_bvalid = 0;
    chk("wr_model_empty", wq.size(), 0);

    // mid-operation drop with two reads outstanding
    s_arvalid = 1; s_arlen = 0;
    s_arid = 4'd3; tick();
    s_arid = 4'd4; tick();
    s_arvalid = 0;
    s_rready = 0;
    mb_reset = 1;
    tick();
    mb_reset = 0;
    #1;
    chk("drop_core_lag", core_reset, 1'b0);
    chk("drop_rready", m_rready, 1'b1);
    tick();
    chk("drop_core_rst", core_reset, 1'b1);
    m_rvalid = 1; m_rlast = 1;
    #1;
    chk("drain_rvalid", s_rvalid, 1'b0);
    tick();
    tick();
    m_rvalid = 0; m_rlast = 0;
    for (int i = 0; i < 60 && core_reset; i++) tick();
    chk("rerelease", core_reset, 1'b0);
    s_rready = 1;
    s_arvalid = 1; s_arid = 4'd7; s_arlen = 0;
    tick();
    s_arvalid = 0;
    m_rvalid = 1; m_rlast = 1;
    #1;
    chk("post_rid7", s_rid, 4'd7);
    chk("post_perr", proto_err, 1'b0);
    tick();
    m_rvalid = 0; m_rlast = 0;

    // stray B with empty write id queue
    tick();
    m_bvalid = 1; s_bready = 1;
    #1;
    chk("stray_bvalid", s_bvalid, 1'b1);
    chk("stray_bid", s_bid, 4'd0);
    tick();
    m_bvalid = 0;
    #1;
    chk("stray_perr", proto_err, 1'b1);
    mb_reset = 1;
    tick();
    mb_reset = 0;
    tick();
    chk("perr_sticky", proto_err, 1'b1);
    reset_n = 0;
    tick();
    chk("perr_clear", proto_err, 1'b0);
    chk("reset_core", core_reset, 1'b1);
    tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
